// File: rtl/wimpfi_pkg.sv
// Shared WimpFi link-layer constants, timing helper and the ACK responder state type.
package wimpfi_pkg;

   localparam logic [7:0] PREAMBLE      = 8'h55;
   localparam logic [7:0] SFD           = 8'hD0;
   localparam logic [7:0] TYPE_DATA     = 8'h30;
   localparam logic [7:0] TYPE_DATA_ACK = 8'h31;
   localparam logic [7:0] TYPE_ACK      = 8'h32;
   localparam logic [7:0] BCAST_ADDR    = 8'h2A;

   localparam int unsigned ACK_LEN = 6;

   typedef enum logic [1:0] {
      ACK_IDLE,
      ACK_SIFS,
      ACK_SEND
   } ack_state_t;

   // Clock cycles spanned by n_bits bit times; evaluated in 64 bits so large clocks do not overflow.
   function automatic longint unsigned bit_time_cycles(input longint unsigned clk_freq,
                                                       input longint unsigned bit_rate,
                                                       input longint unsigned n_bits);
      return (n_bits * clk_freq) / bit_rate;
   endfunction

endpackage

// File: rtl/wimpfi_ack_responder_sifs_timer.sv
// Down-counter for the SIFS gap: loads on request, counts to zero and rests there.
module wimpfi_ack_responder_sifs_timer #(
   parameter int unsigned    CNT_W    = 18,
   parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   output logic zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wimpfi_ack_responder.sv
// Replies to good data frames requesting an ACK: waits one SIFS, then streams a 6-byte ACK frame.
module wimpfi_ack_responder
   import wimpfi_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BIT_RATE  = 50000,
   parameter int unsigned SIFS_BITS = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] src_addr,
   input  logic       rx_frame_valid,
   input  logic [7:0] rx_dest,
   input  logic [7:0] rx_src,
   input  logic [7:0] rx_type,
   input  logic       rx_fcs_ok,
   output logic [7:0] tx_byte,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       tx_last,
   output logic       ack_busy,
   output logic [7:0] ack_drop_cnt
);

   localparam longint unsigned SIFS_CYCLES =
      bit_time_cycles(64'(CLK_FREQ), 64'(BIT_RATE), 64'(SIFS_BITS));
   localparam int unsigned      CNT_W     = $clog2(SIFS_CYCLES + 1);
   localparam logic [CNT_W-1:0] SIFS_LOAD = CNT_W'(SIFS_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(ACK_LEN - 1);

   ack_state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cap_dest_q, cap_dest_d;
   logic [7:0] cap_src_q, cap_src_d;
   logic [7:0] drop_q, drop_d;
   logic       sifs_load;
   logic       sifs_zero;
   logic       qualify;
   logic [7:0] byte_mux;

   // Broadcast is excluded explicitly even if this node were configured with that address.
   assign qualify = rx_frame_valid && rx_fcs_ok && (rx_type == TYPE_DATA_ACK) &&
                    (rx_dest == src_addr) && (rx_dest != BCAST_ADDR);

   wimpfi_ack_responder_sifs_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (SIFS_LOAD)
   ) u_sifs_timer (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (sifs_load),
      .zero_o (sifs_zero)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cap_dest_d = cap_dest_q;
      cap_src_d  = cap_src_q;
      drop_d     = drop_q;
      sifs_load  = 1'b0;

      case (state_q)
         ACK_IDLE: begin
            if (qualify) begin
               state_d    = ACK_SIFS;
               sifs_load  = 1'b1;
               idx_d      = '0;
               cap_dest_d = rx_src;
               cap_src_d  = src_addr;
            end
         end
         ACK_SIFS: begin
            if (sifs_zero) begin
               state_d = ACK_SEND;
            end
         end
         ACK_SEND: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ACK_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ACK_IDLE;
            idx_d   = '0;
         end
      endcase

      // Includes the final-accept cycle: the state is still SEND when the pulse is sampled.
      if (qualify && (state_q != ACK_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ACK_IDLE;
         idx_q      <= '0;
         cap_dest_q <= '0;
         cap_src_q  <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cap_dest_q <= cap_dest_d;
         cap_src_q  <= cap_src_d;
         drop_q     <= drop_d;
      end
   end

   always_comb begin
      case (idx_q)
         3'd0:    byte_mux = PREAMBLE;
         3'd1:    byte_mux = PREAMBLE;
         3'd2:    byte_mux = SFD;
         3'd3:    byte_mux = cap_dest_q;
         3'd4:    byte_mux = cap_src_q;
         3'd5:    byte_mux = TYPE_ACK;
         default: byte_mux = 8'h00;
      endcase
   end

   assign tx_valid     = (state_q == ACK_SEND);
   assign tx_last      = tx_valid && (idx_q == LAST_IDX);
   assign tx_byte      = tx_valid ? byte_mux : 8'h00;
   assign ack_busy     = (state_q != ACK_IDLE);
   assign ack_drop_cnt = drop_q;

endmodule

// File: tb/tb_wimpfi_ack_responder.sv
// Scoreboard bench for the ACK responder, run with a scaled clock so SIFS is 800 cycles.
module tb_wimpfi_ack_responder;

   localparam int unsigned CLK_FREQ  = 500_000;
   localparam int unsigned BIT_RATE  = 50_000;
   localparam int unsigned SIFS_BITS = 80;
   localparam int          SIFS_N    = SIFS_BITS * (CLK_FREQ / BIT_RATE);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] src_addr = 8'h07;
   logic       rx_frame_valid = 1'b0;
   logic [7:0] rx_dest = 8'h00;
   logic [7:0] rx_src = 8'h00;
   logic [7:0] rx_type = 8'h00;
   logic       rx_fcs_ok = 1'b0;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       tx_last;
   logic       ack_busy;
   logic [7:0] ack_drop_cnt;

   int total = 0;
   int bad = 0;
   logic [8:0] exp_q[$];

   wimpfi_ack_responder #(
      .CLK_FREQ  (CLK_FREQ),
      .BIT_RATE  (BIT_RATE),
      .SIFS_BITS (SIFS_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .src_addr       (src_addr),
      .rx_frame_valid (rx_frame_valid),
      .rx_dest        (rx_dest),
      .rx_src         (rx_src),
      .rx_type        (rx_type),
      .rx_fcs_ok      (rx_fcs_ok),
      .tx_byte        (tx_byte),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_last        (tx_last),
      .ack_busy       (ack_busy),
      .ack_drop_cnt   (ack_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] d, input logic [7:0] s, input logic [7:0] t,
                        input logic f);
      rx_dest        = d;
      rx_src         = s;
      rx_type        = t;
      rx_fcs_ok      = f;
      rx_frame_valid = 1'b1;
      step();
      rx_frame_valid = 1'b0;
   endtask

   // Expected entries are {tx_last, tx_byte}.
   task automatic push_ack(input logic [7:0] dest, input logic [7:0] src);
      exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'hD0});
      exp_q.push_back({1'b0, dest});
      exp_q.push_back({1'b0, src});
      exp_q.push_back({1'b1, 8'h32});
      $display("issue ACK expect dest=%02h src=%02h", dest, src);
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 1;
      while (!tx_valid && cyc < SIFS_N + 50) begin
         step();
         cyc++;
      end
      if (!tx_valid) check({name, "_valid_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (ack_busy && n < 200) begin
         step();
         n++;
      end
      check({name, "_busy_low"}, int'(ack_busy), 0);
      check({name, "_valid_low"}, int'(tx_valid), 0);
   endtask

   // Monitor: pops on every accepted byte and checks that stalled bytes hold.
   logic       hold = 1'b0;
   logic [8:0] held = '0;
   always @(negedge clk) begin
      if (!rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", int'(tx_valid), 1);
            check("hold_byte", int'({tx_last, tx_byte}), int'(held));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got 0x%0h expected none at %0t",
                        {tx_last, tx_byte}, $time);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               $display("byte got=%03h exp=%03h", {tx_last, tx_byte}, e);
               check("ack_byte", int'({tx_last, tx_byte}), int'(e));
            end
         end
         hold = tx_valid && !tx_ready;
         held = {tx_last, tx_byte};
      end
   end

   int cyc;
   int busy_hits;
   int pat[4] = '{1, 0, 0, 1};

   initial begin
      repeat (3) step();
      check("rst_valid", int'(tx_valid), 0);
      check("rst_last", int'(tx_last), 0);
      check("rst_byte", int'(tx_byte), 0);
      check("rst_busy", int'(ack_busy), 0);
      check("rst_drop", int'(ack_drop_cnt), 0);
      rst = 1'b1;
      step();

      // Basic ACK with ready held high, including SIFS latency.
      tx_ready = 1'b1;
      push_ack(8'h12, 8'h07);
      pulse(8'h07, 8'h12, 8'h31, 1'b1);
      check("basic_busy_rise", int'(ack_busy), 1);
      wait_valid("basic", cyc);
      check("basic_latency", cyc, SIFS_N + 1);
      wait_idle("basic");

      // Non-qualifying frames: broadcast, plain data, bad FCS.
      for (int v = 0; v < 3; v++) begin
         case (v)
            0:       pulse(8'h2A, 8'h12, 8'h31, 1'b1);
            1:       pulse(8'h07, 8'h12, 8'h30, 1'b1);
            default: pulse(8'h07, 8'h12, 8'h31, 1'b0);
         endcase
         busy_hits = 0;
         for (int i = 0; i < SIFS_N + 200; i++) begin
            if (tx_valid || ack_busy) busy_hits++;
            step();
         end
         $display("nonqual variant=%0d busy_hits=%0d", v, busy_hits);
         check("nonqual_quiet", busy_hits, 0);
      end
      check("nonqual_drop", int'(ack_drop_cnt), 0);

      // Stalled SEND with ready pattern 1,0,0,1.
      tx_ready = 1'b0;
      push_ack(8'h34, 8'h07);
      pulse(8'h07, 8'h34, 8'h31, 1'b1);
      wait_valid("stall", cyc);
      for (int i = 0; i < 100 && ack_busy; i++) begin
         tx_ready = pat[i % 4][0];
         step();
      end
      tx_ready = 1'b1;
      wait_idle("stall");

      // Drop during SIFS and on the final-accept cycle.
      push_ack(8'h12, 8'h07);
      pulse(8'h07, 8'h12, 8'h31, 1'b1);
      repeat (10) step();
      pulse(8'h07, 8'h99, 8'h31, 1'b1);
      cyc = 0;
      while (!tx_last && cyc < SIFS_N + 50) begin
         step();
         cyc++;
      end
      check("drop_saw_last", int'(tx_last), 1);
      pulse(8'h07, 8'h77, 8'h31, 1'b1);
      check("final_valid_low", int'(tx_valid), 0);
      check("final_last_low", int'(tx_last), 0);
      check("final_busy_low", int'(ack_busy), 0);
      check("drop_two", int'(ack_drop_cnt), 2);

      // Saturation of the drop counter while SEND is stalled.
      tx_ready = 1'b0;
      push_ack(8'h21, 8'h07);
      pulse(8'h07, 8'h21, 8'h31, 1'b1);
      wait_valid("sat", cyc);
      for (int i = 0; i < 100; i++) pulse(8'h07, 8'h40, 8'h31, 1'b1);
      check("drop_mid", int'(ack_drop_cnt), 102);
      for (int i = 0; i < 153; i++) pulse(8'h07, 8'h40, 8'h31, 1'b1);
      check("drop_255", int'(ack_drop_cnt), 255);
      for (int i = 0; i < 7; i++) pulse(8'h07, 8'h40, 8'h31, 1'b1);
      check("drop_sat", int'(ack_drop_cnt), 255);
      tx_ready = 1'b1;
      wait_idle("sat");

      // Reset while byte 3 is presented, then a full ACK afterwards.
      tx_ready = 1'b0;
      push_ack(8'h5A, 8'h07);
      pulse(8'h07, 8'h5A, 8'h31, 1'b1);
      wait_valid("rst", cyc);
      tx_ready = 1'b1;
      repeat (3) step();
      tx_ready = 1'b0;
      check("byte3_before_rst", int'(tx_byte), 8'h5A);
      step();
      #1 rst = 1'b0;
      #1;
      check("midrst_valid", int'(tx_valid), 0);
      check("midrst_last", int'(tx_last), 0);
      check("midrst_byte", int'(tx_byte), 0);
      check("midrst_busy", int'(ack_busy), 0);
      check("midrst_drop", int'(ack_drop_cnt), 0);
      exp_q.delete();
      repeat (2) step();
      rst = 1'b1;
      step();
      tx_ready = 1'b1;
      push_ack(8'h66, 8'h07);
      pulse(8'h07, 8'h66, 8'h31, 1'b1);
      wait_valid("post_rst", cyc);
      check("post_rst_latency", cyc, SIFS_N + 1);
      wait_idle("post_rst");
      step();
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wimpfi_ack_responder.md
# wimpfi_ack_responder

Link-layer ACK generator for the WimpFi node. It sits between the receiver's frame-decode output and the transmitter's byte-injection port. When a good frame of type '1' (data, ACK requested) arrives addressed to this node, it waits one SIFS interval and then hands the transmitter a complete ACK frame, one byte at a time. It is the reply half of the ACK exchange whose request half the transmitter already originates.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BIT_RATE`, 50000: channel bit rate in bits/s.
- `SIFS_BITS`, 80: SIFS duration in bit times.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `src_addr` in 8: this node's address.
- `rx_frame_valid` in 1: one-cycle pulse; the receiver has finished a frame and the `rx_*` fields are valid.
- `rx_dest` in 8: destination field of the received frame.
- `rx_src` in 8: source field of the received frame.
- `rx_type` in 8: type field of the received frame.
- `rx_fcs_ok` in 1: FCS check passed, valid with the pulse.
- `tx_byte` out 8: ACK frame byte offered to the transmitter.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_ready` in 1: the transmitter accepts the byte.
- `tx_last` out 1: the current byte is the final frame byte.
- `ack_busy` out 1: high from acceptance of a frame until the final byte is accepted.
- `ack_drop_cnt` out 8: saturating count of qualifying frames dropped because the block was busy.

## Operation
- The ACK frame is 6 bytes, in order:
  - 0x55
  - 0x55
  - 0xD0
  - dest = captured `rx_src`
  - src = `src_addr` (sampled at capture)
  - type = 0x32 ('2')
- The block adds no FCS.
- A frame qualifies when all of the following hold on the `rx_frame_valid` pulse:
  - `rx_fcs_ok` = 1
  - `rx_type` = 0x31
  - `rx_dest` = `src_addr`
  - Broadcast dest 0x2A never qualifies.
- States:
  - IDLE: a qualifying pulse captures the fields and moves to SIFS.
  - SIFS: counts SIFS_CYCLES = SIFS_BITS*CLK_FREQ/BIT_RATE cycles, then moves to SEND. With the defaults this is 160000 cycles.
  - SEND: presents bytes 0..5. The byte index advances on `tx_valid && tx_ready`. Acceptance of byte 5 returns to IDLE.
- A non-qualifying pulse has no effect in any state.
- A qualifying pulse while not in IDLE is dropped. `ack_drop_cnt` increments and holds at 255. Captured fields are not overwritten.
- Carrier sense is not consulted. The ACK is sent after SIFS regardless of channel state.
- Reset values:
  - state IDLE
  - `tx_valid` = 0, `tx_last` = 0, `tx_byte` = 0x00
  - `ack_busy` = 0
  - `ack_drop_cnt` = 0
  - capture registers 0
- Reset asserted mid-frame aborts at once. No partial frame is resumed.

## Timing
- Pulse sampled at edge k: `ack_busy` = 1 from k+1.
- The SIFS counter loads SIFS_CYCLES-1 at k+1 and decrements to 0.
- `tx_valid` first rises exactly SIFS_CYCLES+1 cycles after edge k (first SEND cycle).
- While `tx_valid` = 1 and `tx_ready` = 0, `tx_byte` and `tx_last` hold stable. `tx_valid` never deasserts without acceptance.
- Back-to-back acceptance: one byte per cycle. Minimum SEND duration is 6 cycles.
- `tx_last` = 1 only while byte 5 is presented.
- On acceptance of byte 5: `tx_valid`, `tx_last` and `ack_busy` are 0 the next cycle.
- A qualifying pulse on the same cycle as final-byte acceptance is dropped and counted, because the state is not yet IDLE.
- The SIFS counter width is $clog2(SIFS_CYCLES+1). Compute in 64-bit before truncating.

## Structure
- Shared package `wimpfi_pkg`:
  - constants PREAMBLE (0x55), SFD (0xD0), TYPE_DATA (0x30), TYPE_DATA_ACK (0x31), TYPE_ACK (0x32), BCAST_ADDR (0x2A)
  - localparam function for bit-time cycles
  - state enum `ack_state_t`
- Reuse the existing bit-period counter module for SIFS timing, or inline it; no other sub-module. The byte mux is a case on a 3-bit index.

## Test plan
- src_addr=0x07; pulse with dest=0x07, src=0x12, type=0x31, fcs_ok=1; `tx_ready` held 1 -> bytes 55 55 D0 12 07 32, first `tx_valid` 160001 cycles after pulse, `tx_last` only on 32, `ack_busy` low after.
- Same frame but dest=0x2A, or type=0x30, or fcs_ok=0 -> `tx_valid` and `ack_busy` stay 0 for 200000 cycles.
- During SEND, `tx_ready` toggled 1,0,0,1 -> each byte is held while ready=0, no byte skipped or repeated.
- Second qualifying pulse during SIFS, and another on the final-accept cycle -> `ack_drop_cnt` = 2, first ACK's dest unchanged.
- 260 qualifying pulses while SEND is stalled (ready=0) -> `ack_drop_cnt` saturates at 255.
- `rst` pulsed low during byte 3 -> outputs go to reset values immediately; the next qualifying frame produces a full 6-byte ACK.
